// File: rtl/player_pkg.sv
// player_pkg: shared definitions for the music-player timing path.
// Holds the controller state encoding, the Timer BCD digit width and the default system clock rate.
package player_pkg;

  localparam int BCD_W          = 6;
  localparam int DEFAULT_CLK_HZ = 50_000_000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_FFWD  = 3'd3,
    ST_END   = 3'd4
  } player_state_e;

  // The Timer only advances, and the end of the track is only looked for, in these two states.
  function automatic logic is_running(input player_state_e s);
    return (s == ST_PLAY) || (s == ST_FFWD);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider: counts enabled clock cycles and emits a one-cycle tick once every CLK_HZ of them.
// The count holds while en is low, so a paused period resumes where it left off.
// clr zeroes the count and drops any tick that would otherwise come out of this edge.
// tick_due tells the parent, ahead of the edge, that tick is about to rise.
module tick_divider
  import player_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ,
  parameter int DIV_W  = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic tick_due
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_HZ - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick_due = en && !clr && (div_cnt == LAST);

  // Advance the period counter on enabled cycles and register the wrap as the tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (clr) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (en) begin
      if (div_cnt == LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      tick <= tick_due;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/playback_timer_ctrl.sv
// playback_timer_ctrl: play/pause/stop/fast-forward sequencer for the elapsed-time Timer.
// Generates the one-second count strobe, drives the Timer's reset, count and adder inputs,
// and compares the Timer readback against the track length to detect the end of the track.
module playback_timer_ctrl
  import player_pkg::*;
#(
  parameter int CLK_HZ  = DEFAULT_CLK_HZ,
  parameter int FF_STEP = 5,
  parameter int DIV_W   = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             play_pause,
  input  logic             stop,
  input  logic             ffwd,
  input  logic [BCD_W-1:0] len_m0,
  input  logic [BCD_W-1:0] len_s1,
  input  logic [BCD_W-1:0] len_s0,
  input  logic [BCD_W-1:0] cur_m0,
  input  logic [BCD_W-1:0] cur_s1,
  input  logic [BCD_W-1:0] cur_s0,
  output logic             tmr_clk,
  output logic             tmr_reset,
  output logic             tmr_count,
  output logic [BCD_W-1:0] tmr_adder,
  output logic [2:0]       state,
  output logic             track_done
);

  localparam logic [BCD_W-1:0] ADDER_PLAY = BCD_W'(1);
  localparam logic [BCD_W-1:0] ADDER_FF   = BCD_W'(FF_STEP);

  player_state_e state_q;
  logic          running;
  logic          reached;
  logic          go_end;
  logic          ff_next;
  logic          div_clr;
  logic          tick_due;

  // Digits are valid BCD of equal width, so the concatenations compare as time magnitudes.
  assign running = is_running(state_q);
  assign reached = running && ({cur_m0, cur_s1, cur_s0} >= {len_m0, len_s1, len_s0});
  assign go_end  = reached && !stop && !play_pause;
  assign ff_next = running && ffwd && !stop && !play_pause && !reached;
  assign div_clr = stop || go_end || (state_q == ST_IDLE) || (state_q == ST_END);
  assign state   = state_q;

  tick_divider #(
    .CLK_HZ (CLK_HZ),
    .DIV_W  (DIV_W)
  ) u_tick_divider (
    .clk      (clk),
    .reset    (reset),
    .en       (running),
    .clr      (div_clr),
    .tick     (tmr_clk),
    .tick_due (tick_due)
  );

  // Transport FSM: stop beats play_pause, which beats end detection, which beats ffwd
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tmr_reset  <= 1'b1;
      tmr_count  <= 1'b0;
      tmr_adder  <= ADDER_PLAY;
      track_done <= 1'b0;
    end else begin
      tmr_reset  <= 1'b0;
      track_done <= 1'b0;
      if (!tick_due) begin
        tmr_adder <= ff_next ? ADDER_FF : ADDER_PLAY;
      end
      if (stop) begin
        state_q   <= ST_IDLE;
        tmr_reset <= 1'b1;
        tmr_count <= 1'b0;
      end else if (play_pause) begin
        case (state_q)
          ST_IDLE, ST_PAUSE: begin
            state_q   <= ST_PLAY;
            tmr_count <= 1'b1;
          end
          ST_PLAY, ST_FFWD: begin
            state_q   <= ST_PAUSE;
            tmr_count <= 1'b0;
          end
          ST_END: begin
            state_q   <= ST_PLAY;
            tmr_reset <= 1'b1;
            tmr_count <= 1'b1;
          end
          default: begin
            state_q   <= ST_IDLE;
            tmr_count <= 1'b0;
          end
        endcase
      end else if (reached) begin
        state_q    <= ST_END;
        track_done <= 1'b1;
        tmr_count  <= 1'b0;
      end else if ((state_q == ST_PLAY) && ffwd) begin
        state_q <= ST_FFWD;
      end else if ((state_q == ST_FFWD) && !ffwd) begin
        state_q <= ST_PLAY;
      end
    end
  end

endmodule

// File: tb/tb_playback_timer_ctrl.sv
// tb_playback_timer_ctrl: directed bench for the playback timer controller with a per-cycle
// reference model built from the transport rules and an elapsed-cycle time base.
module tb_playback_timer_ctrl;

  localparam int CLK_HZ  = 10;
  localparam int FF_STEP = 5;
  localparam int DIV_W   = 4;

  localparam int S_IDLE  = 0;
  localparam int S_PLAY  = 1;
  localparam int S_PAUSE = 2;
  localparam int S_FFWD  = 3;
  localparam int S_END   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       play_pause;
  logic       stop;
  logic       ffwd;
  logic [5:0] len_m0, len_s1, len_s0;
  logic [5:0] cur_m0, cur_s1, cur_s0;
  logic       tmr_clk;
  logic       tmr_reset;
  logic       tmr_count;
  logic [5:0] tmr_adder;
  logic [2:0] state;
  logic       track_done;

  int vectors     = 0;
  int miscompares = 0;
  bit check_on    = 1'b0;

  int m_state   = S_IDLE;
  int m_elapsed = 0;
  int m_adder   = 1;
  bit m_strobe  = 1'b0;
  bit m_rst     = 1'b1;
  bit m_done    = 1'b0;

  int strobe_at[$];
  int adder_at[$];

  playback_timer_ctrl #(
    .CLK_HZ  (CLK_HZ),
    .FF_STEP (FF_STEP),
    .DIV_W   (DIV_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .play_pause (play_pause),
    .stop       (stop),
    .ffwd       (ffwd),
    .len_m0     (len_m0),
    .len_s1     (len_s1),
    .len_s0     (len_s0),
    .cur_m0     (cur_m0),
    .cur_s1     (cur_s1),
    .cur_s0     (cur_s0),
    .tmr_clk    (tmr_clk),
    .tmr_reset  (tmr_reset),
    .tmr_count  (tmr_count),
    .tmr_adder  (tmr_adder),
    .state      (state),
    .track_done (track_done)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  function automatic int to_sec(input logic [5:0] m, input logic [5:0] s1, input logic [5:0] s0);
    return int'(m) * 60 + int'(s1) * 10 + int'(s0);
  endfunction

  function automatic int strobe_n(input int i);
    if (i < strobe_at.size()) return strobe_at[i];
    return -1;
  endfunction

  function automatic int adder_n(input int i);
    if (i < adder_at.size()) return adder_at[i];
    return -1;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // One clock edge of the reference: transport rules, then the elapsed-time base.
  task automatic model_step();
    bit running;
    bit ended;
    bit strobe_next;
    int next_st;
    running = (m_state == S_PLAY) || (m_state == S_FFWD);
    ended   = running && (to_sec(cur_m0, cur_s1, cur_s0) >= to_sec(len_m0, len_s1, len_s0));
    next_st = m_state;
    m_rst   = 1'b0;
    m_done  = 1'b0;
    if (stop) begin
      next_st = S_IDLE;
      m_rst   = 1'b1;
    end else if (play_pause) begin
      if (running) begin
        next_st = S_PAUSE;
      end else begin
        next_st = S_PLAY;
        if (m_state == S_END) m_rst = 1'b1;
      end
    end else if (ended) begin
      next_st = S_END;
      m_done  = 1'b1;
    end else if (running) begin
      next_st = ffwd ? S_FFWD : S_PLAY;
    end
    strobe_next = 1'b0;
    if (stop || m_done || m_state == S_IDLE || m_state == S_END) begin
      m_elapsed = 0;
    end else if (running) begin
      m_elapsed++;
      strobe_next = (m_elapsed % CLK_HZ) == 0;
    end
    if (!strobe_next) m_adder = (next_st == S_FFWD) ? FF_STEP : 1;
    m_strobe = strobe_next;
    m_state  = next_st;
  endtask

  // Reference model follows the DUT clock and its asynchronous reset
  always begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_state   = S_IDLE;
      m_elapsed = 0;
      m_adder   = 1;
      m_strobe  = 1'b0;
      m_rst     = 1'b1;
      m_done    = 1'b0;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge
  always begin
    @(negedge clk);
    if (check_on) begin
      checkOutput("cyc_state", int'(state), m_state);
      checkOutput("cyc_tmr_clk", int'(tmr_clk), int'(m_strobe));
      checkOutput("cyc_tmr_reset", int'(tmr_reset), int'(m_rst));
      checkOutput("cyc_tmr_count", int'(tmr_count), (m_state == S_PLAY || m_state == S_FFWD) ? 1 : 0);
      checkOutput("cyc_tmr_adder", int'(tmr_adder), m_adder);
      checkOutput("cyc_track_done", int'(track_done), int'(m_done));
    end
  end

  task automatic applyStimulus(input bit pp, input bit st, input bit ff);
    play_pause = pp;
    stop       = st;
    ffwd       = ff;
    @(posedge clk);
    #1;
    play_pause = 1'b0;
    stop       = 1'b0;
  endtask

  task automatic runCycles(input int n);
    strobe_at.delete();
    adder_at.delete();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (tmr_clk) begin
        strobe_at.push_back(k);
        adder_at.push_back(int'(tmr_adder));
      end
    end
  endtask

  task automatic set_len(input int m, input int s1, input int s0);
    len_m0 = 6'(m);
    len_s1 = 6'(s1);
    len_s0 = 6'(s0);
  endtask

  task automatic set_cur(input int m, input int s1, input int s0);
    cur_m0 = 6'(m);
    cur_s1 = 6'(s1);
    cur_s0 = 6'(s0);
  endtask

  // Hard stop if the directed sequence ever stalls
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected sequence completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed expectations
  initial begin
    reset      = 1'b0;
    play_pause = 1'b0;
    stop       = 1'b0;
    ffwd       = 1'b0;
    set_len(9, 5, 9);
    set_cur(0, 0, 0);
    check_on   = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    checkOutput("rst_state", int'(state), S_IDLE);
    checkOutput("rst_tmr_reset_held", int'(tmr_reset), 1);
    checkOutput("rst_tmr_count", int'(tmr_count), 0);
    checkOutput("rst_tmr_adder", int'(tmr_adder), 1);
    @(posedge clk);
    #1;
    checkOutput("rst_tmr_reset_released", int'(tmr_reset), 0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    runCycles(35);
    checkOutput("play_strobe_cnt", strobe_at.size(), 3);
    checkOutput("play_strobe0", strobe_n(0), 10);
    checkOutput("play_strobe1", strobe_n(1), 20);
    checkOutput("play_strobe2", strobe_n(2), 30);
    checkOutput("play_state", int'(state), S_PLAY);
    checkOutput("play_count", int'(tmr_count), 1);

    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    runCycles(13);
    checkOutput("prepause_strobe", strobe_n(0), 10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    runCycles(50);
    checkOutput("pause_strobe_cnt", strobe_at.size(), 0);
    checkOutput("pause_state", int'(state), S_PAUSE);
    checkOutput("pause_count", int'(tmr_count), 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("resume_state", int'(state), S_PLAY);
    ffwd = 1'b0;
    runCycles(12);
    checkOutput("resume_strobe_cnt", strobe_at.size(), 1);
    checkOutput("resume_strobe0", strobe_n(0), 6);

    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("ffwd_adder_early", int'(tmr_adder), FF_STEP);
    runCycles(25);
    checkOutput("ffwd_strobe_cnt", strobe_at.size(), 3);
    checkOutput("ffwd_strobe0", strobe_n(0), 3);
    checkOutput("ffwd_adder_at_strobe", adder_n(0), FF_STEP);
    checkOutput("ffwd_state", int'(state), S_FFWD);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ffwd_drop_state", int'(state), S_PLAY);
    checkOutput("ffwd_drop_adder", int'(tmr_adder), 1);

    set_len(0, 1, 2);
    set_cur(0, 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    runCycles(2);
    checkOutput("end_not_yet", int'(state), S_FFWD);
    set_cur(0, 1, 5);
    @(posedge clk);
    #1;
    checkOutput("end_state", int'(state), S_END);
    checkOutput("end_done", int'(track_done), 1);
    checkOutput("end_count", int'(tmr_count), 0);
    @(posedge clk);
    #1;
    checkOutput("end_done_pulse", int'(track_done), 0);
    runCycles(25);
    checkOutput("end_strobe_cnt", strobe_at.size(), 0);
    checkOutput("end_hold_state", int'(state), S_END);
    set_cur(0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("replay_state", int'(state), S_PLAY);
    checkOutput("replay_tmr_reset", int'(tmr_reset), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stop_state", int'(state), S_IDLE);
    checkOutput("stop_tmr_reset", int'(tmr_reset), 1);

    set_len(0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("zero_len_play", int'(state), S_PLAY);
    @(posedge clk);
    #1;
    checkOutput("zero_len_end", int'(state), S_END);
    checkOutput("zero_len_done", int'(track_done), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    set_len(9, 5, 9);

    applyStimulus(1'b1, 1'b0, 1'b0);
    runCycles(5);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("both_state", int'(state), S_IDLE);
    checkOutput("both_tmr_reset", int'(tmr_reset), 1);
    @(posedge clk);
    #1;
    checkOutput("both_tmr_reset_pulse", int'(tmr_reset), 0);
    checkOutput("both_state_hold", int'(state), S_IDLE);
    applyStimulus(1'b1, 1'b0, 1'b0);
    runCycles(12);
    checkOutput("both_restart_strobe_cnt", strobe_at.size(), 1);
    checkOutput("both_restart_strobe0", strobe_n(0), 10);

    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    runCycles(7);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_state", int'(state), S_IDLE);
    checkOutput("midrst_tmr_clk", int'(tmr_clk), 0);
    checkOutput("midrst_tmr_reset", int'(tmr_reset), 1);
    checkOutput("midrst_tmr_count", int'(tmr_count), 0);
    checkOutput("midrst_tmr_adder", int'(tmr_adder), 1);
    checkOutput("midrst_done", int'(track_done), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    runCycles(12);
    checkOutput("midrst_restart_strobe_cnt", strobe_at.size(), 1);
    checkOutput("midrst_restart_strobe0", strobe_n(0), 10);
    checkOutput("midrst_restart_state", int'(state), S_PLAY);

    @(negedge clk);
    check_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
